// File: rtl/bitmanip_pkg.sv
// Shared types and constants for the bit-extract / bit-deposit execution unit.
package bitmanip_pkg;

    localparam int unsigned XLEN_C  = 32;
    localparam int unsigned TAG_W_C = 5;

    typedef enum logic {
        OP_BEXT = 1'b0,
        OP_BDEP = 1'b1
    } op_e;

    // Exclusive prefix count of the mask, one per bit lane; never exceeds 31.
    typedef logic [4:0] prefix_cnt_t;

    typedef struct packed {
        op_e                 op;
        logic [XLEN_C-1:0]   rs1;
        logic [XLEN_C-1:0]   rs2;
        logic [TAG_W_C-1:0]  tag;
    } extdep_req_t;

endpackage

// File: rtl/extdep_skid_buf.sv
// One-entry skid buffer; in_ready depends only on the registered "buffer empty" state
// (and flush), so the downstream ready never reaches in_ready combinationally.
module extdep_skid_buf
    import bitmanip_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  extdep_req_t in_req,
    output logic        out_valid,
    input  logic        out_ready,
    output extdep_req_t out_req
);

    logic        skid_valid_q, skid_valid_d;
    extdep_req_t skid_req_q, skid_req_d;

    assign in_ready  = !skid_valid_q && !flush;
    assign out_valid = skid_valid_q || (in_valid && !flush);
    assign out_req   = skid_valid_q ? skid_req_q : in_req;

    // Park an accepted request when downstream stalls; drain it once downstream frees up.
    always_comb begin
        skid_valid_d = skid_valid_q;
        skid_req_d   = skid_req_q;
        if (flush) begin
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            if (out_ready) skid_valid_d = 1'b0;
        end else if (in_valid && !out_ready) begin
            skid_valid_d = 1'b1;
            skid_req_d   = in_req;
        end
    end

    // Skid state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            skid_valid_q <= 1'b0;
            skid_req_q   <= '0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_req_q   <= skid_req_d;
        end
    end

endmodule

// File: rtl/popcnt.sv
// Inclusive prefix population count: pcnt[i] = popcount(mask[i:0]).
module popcnt
    import bitmanip_pkg::*;
#(
    parameter int unsigned W = 31
) (
    input  logic        [W-1:0] mask,
    output prefix_cnt_t [W-1:0] pcnt
);

    // Running sum across the lanes; W <= 31 keeps every count within 5 bits.
    always_comb begin
        prefix_cnt_t acc;
        acc = '0;
        for (int unsigned i = 0; i < W; i++) begin
            acc     = acc + prefix_cnt_t'(mask[i]);
            pcnt[i] = acc;
        end
    end

endmodule

// File: rtl/bitmask_extdep_pipe.sv
// Two-stage elastic bext/bdep unit. S1 registers the request and the exclusive prefix
// counts of the mask; S2 gathers/scatters the data bits and registers the result.
// Define BITMASK_EXTDEP_SKID_EN to put a one-entry skid buffer on the input.
module bitmask_extdep_pipe
    import bitmanip_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_C,
    parameter int unsigned TAG_W = TAG_W_C
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_op,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
);

    extdep_req_t in_req, pipe_req;
    logic        pipe_valid, pipe_ready;
    logic        s1_load, s2_adv;

    logic                      s1_valid_q, s1_valid_d;
    extdep_req_t               s1_req_q, s1_req_d;
    prefix_cnt_t [XLEN_C-1:0]  s1_ex_q, s1_ex_d;
    logic                      s2_valid_q, s2_valid_d;
    logic [XLEN-1:0]           s2_result_q, s2_result_d;
    logic [TAG_W-1:0]          s2_tag_q, s2_tag_d;

    prefix_cnt_t [XLEN_C-2:0]  pcnt;
    prefix_cnt_t [XLEN_C-1:0]  ex;
    logic [XLEN-1:0]           result;

    // Bundle the issue-side operands.
    always_comb begin
        in_req.op  = op_e'(in_op);
        in_req.rs1 = in_rs1;
        in_req.rs2 = in_rs2;
        in_req.tag = in_tag;
    end

`ifdef BITMASK_EXTDEP_SKID_EN
    extdep_skid_buf u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_req    (in_req),
        .out_valid (pipe_valid),
        .out_ready (pipe_ready),
        .out_req   (pipe_req)
    );
`else
    assign pipe_valid = in_valid;
    assign pipe_req   = in_req;
    assign in_ready   = pipe_ready && !flush;
`endif

    assign s2_adv     = !s2_valid_q || out_ready;
    assign pipe_ready = !s1_valid_q || s2_adv;
    assign s1_load    = pipe_valid && pipe_ready && !flush;

    // Bit 31 of the mask never contributes to an exclusive count.
    popcnt #(
        .W (XLEN_C - 1)
    ) u_popcnt (
        .mask (pipe_req.rs2[XLEN_C-2:0]),
        .pcnt (pcnt)
    );

    // ex[i] = popcount(rs2[i-1:0]).
    always_comb begin
        ex[0] = '0;
        for (int unsigned i = 1; i < XLEN_C; i++) begin
            ex[i] = pcnt[i-1];
        end
    end

    // S1 next state: flush wins, then load, then drain into S2.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_req_d   = s1_req_q;
        s1_ex_d    = s1_ex_q;
        if (flush) begin
            s1_valid_d = 1'b0;
        end else if (s1_load) begin
            s1_valid_d = 1'b1;
            s1_req_d   = pipe_req;
            s1_ex_d    = ex;
        end else if (pipe_ready) begin
            s1_valid_d = 1'b0;
        end
    end

    // Gather (bext) or scatter (bdep) using the registered prefix counts.
    always_comb begin
        result = '0;
        for (int unsigned i = 0; i < XLEN_C; i++) begin
            if (s1_req_q.op == OP_BEXT) begin
                if (s1_req_q.rs2[i]) result[s1_ex_q[i]] = s1_req_q.rs1[i];
            end else begin
                result[i] = s1_req_q.rs2[i] & s1_req_q.rs1[s1_ex_q[i]];
            end
        end
    end

    // S2 next state: result and tag only change when the stage advances.
    always_comb begin
        s2_valid_d  = s2_valid_q;
        s2_result_d = s2_result_q;
        s2_tag_d    = s2_tag_q;
        if (flush) begin
            s2_valid_d = 1'b0;
        end else if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_result_d = result;
                s2_tag_d    = s1_req_q.tag;
            end
        end
    end

    // Pipeline registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_req_q    <= '0;
            s1_ex_q     <= '0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_tag_q    <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_req_q    <= s1_req_d;
            s1_ex_q     <= s1_ex_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_tag_q    <= s2_tag_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_result = s2_result_q;
    assign out_tag    = s2_tag_q;

endmodule

// File: tb/tb_bitmask_extdep_pipe.sv
// Directed bench for bitmask_extdep_pipe with hand-computed expected values.
module tb_bitmask_extdep_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_op = 1'b0;
    logic [31:0] in_rs1 = '0;
    logic [31:0] in_rs2 = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [4:0]  out_tag;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bitmask_extdep_pipe dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_result !== 32'h0 || out_tag !== 5'h0) begin
            errors++;
            $display("FAIL reset_state: got valid=%b result=%h tag=%h required 0/0/0",
                     out_valid, out_result, out_tag);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
    endtask

    task automatic test_basic();
        logic        ops [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [31:0] rs1 [10] = '{32'hDEADBEEF, 32'h000000BE, 32'hAAAAAAAA, 32'h12345678,
                                  32'h12345678, 32'h12345678, 32'h12345678, 32'h0000FFFF,
                                  32'h80000001, 32'h00000003};
        logic [31:0] rs2 [10] = '{32'h0000FF00, 32'hFF000000, 32'hAAAAAAAA, 32'h00000000,
                                  32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hAAAAAAAA,
                                  32'h80000001, 32'h80000001};
        logic [31:0] exp [10] = '{32'h000000BE, 32'hBE000000, 32'h0000FFFF, 32'h00000000,
                                  32'h00000000, 32'h12345678, 32'h12345678, 32'hAAAAAAAA,
                                  32'h00000003, 32'h80000001};
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_op    = ops[i];
            in_rs1   = rs1[i];
            in_rs2   = rs2[i];
            in_tag   = 5'(i + 3);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL basic_in_ready[%0d]: got %b required 1", i, in_ready);
            end
            tick();
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL basic_latency_early[%0d]: got out_valid=%b required 0",
                         i, out_valid);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_result !== exp[i] || out_tag !== 5'(i + 3)) begin
                errors++;
                $display("FAIL basic_result[%0d]: got valid=%b result=%h tag=%0d required 1 %h %0d",
                         i, out_valid, out_result, out_tag, exp[i], i + 3);
            end
        end
    endtask

    task automatic test_throughput();
        logic [31:0] vals [4] = '{32'h01234567, 32'h89ABCDEF, 32'hF0F0F0F0, 32'h0F0F0F0F};
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_valid = (k < 4);
            in_op    = 1'b0;
            in_rs1   = (k < 4) ? vals[k] : 32'h0;
            in_rs2   = 32'hFFFFFFFF;
            in_tag   = 5'(k);
            #1;
            if (k < 4) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL thru_in_ready[%0d]: got %b required 1", k, in_ready);
                end
            end
            if (k >= 2) begin
                checks++;
                if (out_valid !== 1'b1 || out_result !== vals[k-2]) begin
                    errors++;
                    $display("FAIL thru_out[%0d]: got valid=%b result=%h required 1 %h",
                             k, out_valid, out_result, vals[k-2]);
                end
            end
            tick();
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] rs1 [8];
        logic [31:0] exp [8];
        int          sent = 0;
        int          rcv = 0;
        logic        held = 1'b0;
        logic        acc;
        logic [31:0] held_res = '0;
        logic [4:0]  held_tag = '0;
        for (int i = 0; i < 8; i++) begin
            rs1[i] = 32'hA5A50000 | 32'(16'(i * 16'h1111 + 1));
            exp[i] = (i % 2 == 1) ? {rs1[i][15:0], 16'h0000} : {16'h0000, rs1[i][15:0]};
        end
        for (int cyc = 0; cyc < 100 && rcv < 8; cyc++) begin
            out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            if (sent < 8) begin
                in_valid = 1'b1;
                in_op    = sent[0];
                in_rs1   = rs1[sent];
                in_rs2   = sent[0] ? 32'hFFFF0000 : 32'h0000FFFF;
                in_tag   = 5'(sent + 8);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (held) begin
                checks++;
                if (out_valid !== 1'b1 || out_result !== held_res || out_tag !== held_tag) begin
                    errors++;
                    $display("FAIL b2b_stall_stable: got valid=%b result=%h tag=%0d required 1 %h %0d",
                             out_valid, out_result, out_tag, held_res, held_tag);
                end
            end
            if (out_valid === 1'b1) begin
                if (out_ready) begin
                    checks++;
                    if (out_result !== exp[rcv] || out_tag !== 5'(rcv + 8)) begin
                        errors++;
                        $display("FAIL b2b_order[%0d]: got result=%h tag=%0d required %h %0d",
                                 rcv, out_result, out_tag, exp[rcv], rcv + 8);
                    end
                    rcv++;
                    held = 1'b0;
                end else begin
                    held     = 1'b1;
                    held_res = out_result;
                    held_tag = out_tag;
                end
            end
            acc = in_valid && in_ready;
            tick();
            if (acc) sent++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (rcv != 8) begin
            errors++;
            $display("FAIL b2b_count: got %0d results required 8 (cycle budget)", rcv);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_duplicate: got out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_op = 1'b0;
        in_rs1 = 32'h11111111;
        in_rs2 = 32'hFFFFFFFF;
        in_tag = 5'd1;
        tick();
        in_rs1 = 32'h22222222;
        in_tag = 5'd2;
        tick();
        in_rs1 = 32'h33333333;
        in_tag = 5'd3;
        flush = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_during: got in_ready=%b out_valid=%b required 0 1",
                     in_ready, out_valid);
        end
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_kill: got out_valid=%b required 0", out_valid);
        end
        in_valid = 1'b1;
        in_op = 1'b1;
        in_rs1 = 32'h000000BE;
        in_rs2 = 32'hFF000000;
        in_tag = 5'd9;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_recover_ready: got %b required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_stale: got out_valid=%b result=%h required 0",
                     out_valid, out_result);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_result !== 32'hBE000000 || out_tag !== 5'd9) begin
            errors++;
            $display("FAIL flush_next_op: got valid=%b result=%h tag=%0d required 1 be000000 9",
                     out_valid, out_result, out_tag);
        end
        tick();
    endtask

    task automatic test_reset_mid_op();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_op = 1'b0;
        in_rs1 = 32'h44444444;
        in_rs2 = 32'hFFFFFFFF;
        in_tag = 5'd4;
        tick();
        in_rs1 = 32'h55555555;
        in_tag = 5'd5;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_result !== 32'h0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_op: got valid=%b result=%h in_ready=%b required 0 0 1",
                     out_valid, out_result, in_ready);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_no_stale[%0d]: got out_valid=%b result=%h required 0",
                         k, out_valid, out_result);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_throughput();
        test_back_to_back();
        test_flush();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bitmask_extdep_pipe.md
Name: bitmask_extdep_pipe

Overview:
- Pipelined bit-extract (bext) and bit-deposit (bdep) execution unit for the 32-bit bit-manipulation extension.
- Sits directly downstream of the prefix population-count stage (popcnt). It consumes the per-bit prefix counts of the mask operand to gather or scatter data bits.
- Issues from the ALU dispatch with a valid/ready handshake and returns results to writeback with a valid/ready handshake.
- Two-stage elastic pipeline, one operation per cycle at full throughput.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- TAG_W, 5, width of the destination-register tag carried alongside the data.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  kills all in-flight operations.
- in_valid  input  1  operation presented.
- in_ready  output  1  unit accepts the operation this cycle.
- in_op  input  1  0 = bext, 1 = bdep.
- in_rs1  input  XLEN  data operand.
- in_rs2  input  XLEN  mask operand.
- in_tag  input  TAG_W  destination tag.
- out_valid  output  1  result available.
- out_ready  input  1  writeback accepts the result.
- out_result  output  XLEN  result.
- out_tag  output  TAG_W  tag of the result.

Behaviour:
- Reset (synchronous, active-high):
  - s1_valid, s2_valid and out_valid are 0.
  - out_result and out_tag are 0.
  - in_ready is 1 from the first cycle after reset deasserts.
  - Reset asserted mid-operation discards all in-flight operations; no partial result is emitted.
- Stage S1 (accept):
  - The transfer occurs when in_valid && in_ready.
  - The stage registers op, rs1, tag, rs2 and the exclusive prefix count ex[i] = popcount(rs2[i-1:0]), with ex[0] = 0.
  - ex[i] is taken from the popcnt instance, 5 bits per lane, i = 0..31.
- Stage S2 (compute/output):
  - bext: result[ex[i]] = rs1[i] for every i with rs2[i] = 1. All bits at index ≥ popcount(rs2) are 0.
  - bdep: result[i] = rs2[i] ? rs1[ex[i]] : 0.
  - The result is registered. out_valid = s2_valid.
- Latency: 2 cycles from the accepting edge to out_valid, when not stalled.
- Stall rules:
  - A stage advances when it is empty or the stage ahead advances. in_ready = !s1_valid || s1_advance.
  - S2 holds out_result and out_tag stable while out_valid && !out_ready.
  - A full pipeline stalled by out_ready = 0 deasserts in_ready in the same cycle (combinational path without the skid option).
- Simultaneous events:
  - Accept and output in the same cycle is allowed; the pipeline moves in lockstep.
  - flush takes priority over in_valid. On the next edge s1_valid and s2_valid clear; an input offered during flush is not accepted, and in_ready is 0 while flush is high.
- Boundary conditions:
  - rs2 = 0: result is 0 for both ops.
  - rs2 = 0xFFFFFFFF: result is rs1 for both ops.
  - ex never exceeds 31, so there is no wrap-around.
- Ordering: results leave in acceptance order; no reordering.

Optional Feature:
- Macro: BITMASK_EXTDEP_SKID_EN.
- When defined, a one-entry skid buffer sits on the input, and in_ready is driven from a register (skid buffer empty). This breaks the out_ready→in_ready combinational path; throughput stays 1 per cycle and latency is unchanged (2 cycles).
- flush and rst also clear the skid buffer.
- When not defined, there is no skid buffer and in_ready follows combinationally as described above.

Decomposition:
- Package bitmanip_pkg:
  - XLEN_C constant.
  - op_e enum {OP_BEXT, OP_BDEP}.
  - Struct extdep_req_t {op, rs1, rs2, tag}.
  - Typedef prefix_cnt_t = logic [4:0].
- Sub-module: the existing popcnt instantiated in S1. The exclusive count vector ex is built from its outputs as ex[i] = pcnt(i-1).
- Optional sub-module: extdep_skid_buf, used only under BITMASK_EXTDEP_SKID_EN.

Test Plan:
- bext, rs1=0xDEADBEEF, rs2=0x0000FF00 → out_result=0x000000BE, out_valid exactly 2 cycles after accept.
- bdep, rs1=0x000000BE, rs2=0xFF000000 → 0xBE000000. bext, rs1=0xAAAAAAAA, rs2=0xAAAAAAAA → 0x0000FFFF.
- Masks 0x00000000 and 0xFFFFFFFF with rs1=0x12345678, both ops → 0x00000000 and 0x12345678 respectively.
- Back-to-back 8 operations with out_ready toggling 1,0,0,1: results in order, no drops or duplicates, out_result stable while stalled, throughput 1/cycle when out_ready=1.
- Two ops in flight, flush pulsed one cycle → neither emerges; the next op accepted after flush completes with correct result and 2-cycle latency.
- rst asserted for 1 cycle with a full pipeline → out_valid=0 the next cycle, in_ready=1 the cycle after reset deasserts, and no stale result afterwards.
